// File: rtl/apb_uart_pkg.sv
// Shared constants and state types for the APB UART bridge.
// Optional parity support is compiled in with UART_PARITY_EN.
package apb_uart_pkg;

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DIV    = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVR      = 4;
    localparam int ST_FERR     = 5;
    localparam int ST_PERR     = 6;
    localparam int ST_TX_BUSY  = 7;

    localparam int CT_TX_EN    = 0;
    localparam int CT_RX_EN    = 1;
    localparam int CT_IRQ_RX   = 2;
    localparam int CT_IRQ_TX   = 3;
    localparam int CT_IRQ_ERR  = 4;
    localparam int CT_PAR_EN   = 5;

    localparam logic [15:0] MIN_DIV = 16'd3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    // Bit period is this value + 1 cycles.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/apb_uart_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
module apb_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_uart_bridge.sv
// APB slave UART with TX/RX FIFOs, programmable divisor and level irq.
// Define UART_PARITY_EN to build in even-parity generation and checking.
module apb_uart_bridge
    import apb_uart_pkg::*;
#(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int             BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

    logic                 acc, wr, rd, sel_data, sel_status, sel_div, sel_ctrl, addr_ok;
    logic [7:0]           addr_w, status;
    logic [15:0]          div_q;
    logic [5:0]           ctrl_q;
    logic [2:0]           flags;  // {perr, ferr, ovr}
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_rdata, rx_rdata;
    tx_state_t            tx_state, tx_nstate;
    rx_state_t            rx_state, rx_nstate;
    logic [15:0]          tx_cnt, tx_div, rx_cnt, rx_div;
    logic [DATA_BITS-1:0] tx_shift, rx_shift;
    logic [BW-1:0]        tx_idx, rx_idx;
    logic                 tx_load, tx_tick, rx_arm, rx_tick, rx_fall;
    logic                 rx_s1, rx_s2, rx_prev;
    logic                 set_ovr, set_ferr, set_perr;
    logic                 unused_bits;
`ifdef UART_PARITY_EN
    logic                 tx_par, rx_pbad;
`endif

    assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

    assign acc        = PSEL & PENABLE;
    assign wr         = acc & PWRITE;
    assign rd         = acc & ~PWRITE;
    assign addr_w     = {PADDR[7:2], 2'b00};
    assign sel_data   = (addr_w == OFF_DATA);
    assign sel_status = (addr_w == OFF_STATUS);
    assign sel_div    = (addr_w == OFF_DIV);
    assign sel_ctrl   = (addr_w == OFF_CTRL);
    assign addr_ok    = sel_data | sel_status | sel_div | sel_ctrl;
    assign PREADY     = 1'b1;
    assign tx_push    = wr & sel_data & ~tx_full;
    assign rx_pop     = rd & sel_data & ~rx_empty;

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVR]      = flags[0];
        status[ST_FERR]     = flags[1];
        status[ST_PERR]     = flags[2];
        status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
    end

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (acc) begin
            if (!addr_ok) begin
                PSLVERR = 1'b1;
            end else if (sel_data) begin
                if (PWRITE)        PSLVERR = tx_full;
                else if (rx_empty) PSLVERR = 1'b1;
                else               PRDATA  = {{(32-DATA_BITS){1'b0}}, rx_rdata};
            end else if (!PWRITE) begin
                if (sel_status)   PRDATA = {24'd0, status};
                else if (sel_div) PRDATA = {16'd0, div_q};
                else              PRDATA = {26'd0, ctrl_q};
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_q  <= DIV_RESET;
            ctrl_q <= '0;
            flags  <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && sel_div) div_q <= PWDATA[15:0];
`ifdef UART_PARITY_EN
            if (wr && sel_ctrl) ctrl_q <= PWDATA[5:0];
`else
            if (wr && sel_ctrl) ctrl_q <= {1'b0, PWDATA[4:0]};
`endif
            // A new error in the same cycle as a clear wins.
            flags <= (flags & ~((wr && sel_status) ? PWDATA[6:4] : 3'b000))
                   | {set_perr, set_ferr, set_ovr};
            irq   <= (ctrl_q[CT_IRQ_RX] & ~rx_empty)
                   | (ctrl_q[CT_IRQ_TX] & tx_empty & (tx_state == TX_IDLE))
                   | (ctrl_q[CT_IRQ_ERR] & (|flags));
        end
    end

    apb_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .pop(tx_pop),
        .wdata(PWDATA[DATA_BITS-1:0]), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    apb_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rx_pop),
        .wdata(rx_shift), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- transmitter ----------------
    assign tx_tick = (tx_cnt == 16'd0);

    always_comb begin
        tx_nstate = tx_state;
        tx_pop    = 1'b0;
        tx_load   = 1'b0;
        case (tx_state)
            TX_IDLE: if (ctrl_q[CT_TX_EN] && !tx_empty) begin
                tx_pop = 1'b1; tx_load = 1'b1; tx_nstate = TX_START;
            end
            TX_START: if (tx_tick) tx_nstate = TX_DATA;
            TX_DATA: if (tx_tick && tx_idx == LAST_BIT) begin
                tx_nstate = TX_STOP;
`ifdef UART_PARITY_EN
                if (ctrl_q[CT_PAR_EN]) tx_nstate = TX_PARITY;
`endif
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_tick) tx_nstate = TX_STOP;
`endif
            TX_STOP: if (tx_tick) begin
                if (ctrl_q[CT_TX_EN] && !tx_empty) begin
                    tx_pop = 1'b1; tx_load = 1'b1; tx_nstate = TX_START;
                end else begin
                    tx_nstate = TX_IDLE;
                end
            end
            default: tx_nstate = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= MIN_DIV;
            tx_shift <= '0;
            tx_idx   <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_nstate;
            if (tx_load) begin
                // Divisor is latched per character so DIV writes never stretch a bit.
                tx_shift <= tx_rdata;
                tx_cnt   <= eff_div(div_q);
                tx_div   <= eff_div(div_q);
                tx_idx   <= '0;
`ifdef UART_PARITY_EN
                tx_par   <= ^tx_rdata;
`endif
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= tx_div;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + BW'(1);
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx = tx_par;
`endif
            default:   tx = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = (rx_cnt == 16'd0);

    always_comb begin
        rx_nstate = rx_state;
        rx_arm    = 1'b0;
        rx_push   = 1'b0;
        set_ovr   = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;
        case (rx_state)
            RX_IDLE: if (ctrl_q[CT_RX_EN] && rx_fall) begin
                rx_arm = 1'b1; rx_nstate = RX_START;
            end
            RX_START: if (rx_tick) rx_nstate = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: if (rx_tick && rx_idx == LAST_BIT) begin
                rx_nstate = RX_STOP;
`ifdef UART_PARITY_EN
                if (ctrl_q[CT_PAR_EN]) rx_nstate = RX_PARITY;
`endif
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_tick) rx_nstate = RX_STOP;
`endif
            RX_STOP: if (rx_tick) begin
                if (!rx_s2) begin
                    set_ferr  = 1'b1;
                    rx_nstate = RX_WAIT;
                end else begin
                    rx_nstate = RX_IDLE;
`ifdef UART_PARITY_EN
                    if (rx_pbad) set_perr = 1'b1; else
`endif
                    if (rx_full) set_ovr = 1'b1;
                    else         rx_push = 1'b1;
                end
            end
            // Break / framing error: don't re-arm on a line that is still low.
            RX_WAIT: if (rx_s2) rx_nstate = RX_IDLE;
            default: rx_nstate = RX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= MIN_DIV;
            rx_shift <= '0;
            rx_idx   <= '0;
`ifdef UART_PARITY_EN
            rx_pbad  <= 1'b0;
`endif
        end else begin
            rx_state <= rx_nstate;
            if (rx_arm) begin
                rx_cnt  <= eff_div(div_q) >> 1;
                rx_div  <= eff_div(div_q);
                rx_idx  <= '0;
`ifdef UART_PARITY_EN
                rx_pbad <= 1'b0;
`endif
            end else if (rx_state != RX_IDLE && rx_state != RX_WAIT) begin
                if (rx_tick) begin
                    rx_cnt <= rx_div;
                    if (rx_state == RX_DATA) begin
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        rx_idx   <= rx_idx + BW'(1);
                    end
`ifdef UART_PARITY_EN
                    if (rx_state == RX_PARITY) rx_pbad <= rx_s2 ^ (^rx_shift);
`endif
                end else begin
                    rx_cnt <= rx_cnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Directed self-checking bench for apb_uart_bridge (default parameters).
module tb_apb_uart_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    wire  [31:0] PRDATA;
    wire         PREADY, PSLVERR, tx, irq;
    logic        rx_drv = 1'b1, loop = 1'b0, last_rdy;
    wire         rx = loop ? tx : rx_drv;
    int          total = 0, bad = 0;

    apb_uart_bridge dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 begin d = PRDATA; err = PSLVERR; last_rdy = PREADY; end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int i = 0;
        while (tx !== 1'b0 && i < 300) begin
            @(negedge PCLK);
            i++;
        end
        check(tag, tx, 1'b0);
    endtask

    task automatic capture(input int n, output logic [399:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[i] = tx;
            @(negedge PCLK);
        end
    endtask

    task automatic rx_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (4) @(negedge PCLK);
        end
    endtask

    // Expected line level per cycle (bit 0 = first cycle) for a 4-cycle bit period.
    function automatic logic [39:0] frame(input logic [7:0] d);
        logic [39:0] f;
        logic        b;
        for (int i = 0; i < 10; i++) begin
            b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            for (int c = 0; c < 4; c++) f[i*4+c] = b;
        end
        return f;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic        err;
        logic [31:0] d;
        logic [399:0] w;

        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_tx", tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("idle_prdata", PRDATA, 32'h0);
        check("idle_slverr", PSLVERR, 1'b0);
        apb_rd(8'h04, d, err);
        check("rst_status", d, 32'h06);
        check("rst_status_err", err, 1'b0);
        check("pready", last_rdy, 1'b1);
        apb_rd(8'h08, d, err);
        check("rst_div", d, 32'd433);
        apb_rd(8'h0C, d, err);
        check("rst_ctrl", d, 32'h0);

        apb_wr(8'h10, 32'hFF, err);
        check("bad_addr_wr_err", err, 1'b1);
        apb_rd(8'h10, d, err);
        check("bad_addr_rd_err", err, 1'b1);
        check("bad_addr_rd_data", d, 32'h0);
        apb_rd(8'h00, d, err);
        check("empty_rd_err", err, 1'b1);
        check("empty_rd_data", d, 32'h0);

        // Single character waveform at period 4.
        apb_wr(8'h08, 32'd3, err);
        apb_rd(8'h08, d, err);
        check("div_rw", d, 32'd3);
        apb_wr(8'h0C, 32'h01, err);
        apb_wr(8'h00, 32'hA5, err);
        check("a5_wr_err", err, 1'b0);
        wait_start("a5_start");
        capture(44, w);
        check("a5_frame", w[39:0], frame(8'hA5));
        check("a5_idle_after", w[43:40], 4'hF);
        apb_rd(8'h04, d, err);
        check("a5_busy_after", d[7], 1'b0);

        // Loopback two characters.
        loop = 1'b1;
        apb_wr(8'h0C, 32'h03, err);
        apb_wr(8'h00, 32'h3C, err);
        apb_wr(8'h00, 32'hC3, err);
        repeat (120) @(negedge PCLK);
        apb_wr(8'h0C, 32'h07, err);
        @(negedge PCLK);
        check("irq_rx", irq, 1'b1);
        apb_rd(8'h00, d, err);
        check("loop_rd1", d, 32'h3C);
        check("loop_rd1_err", err, 1'b0);
        apb_rd(8'h00, d, err);
        check("loop_rd2", d, 32'hC3);
        check("loop_rd2_err", err, 1'b0);
        apb_rd(8'h00, d, err);
        check("loop_rd3_err", err, 1'b1);
        check("loop_rd3_data", d, 32'h0);
        repeat (2) @(negedge PCLK);
        check("irq_rx_clear", irq, 1'b0);
        loop = 1'b0;
        apb_wr(8'h0C, 32'h00, err);

        // Fill TX FIFO with transmitter disabled, then drain back-to-back.
        for (int k = 0; k < 8; k++) begin
            apb_wr(8'h00, 32'(k * 17), err);
            check("fill_err", err, 1'b0);
        end
        apb_wr(8'h00, 32'hEE, err);
        check("overfill_err", err, 1'b1);
        apb_rd(8'h04, d, err);
        check("full_status", d, 32'h05);
        apb_wr(8'h0C, 32'h01, err);
        wait_start("b2b_start");
        capture(328, w);
        for (int k = 0; k < 8; k++) check("b2b_char", w[k*40 +: 40], frame(8'(k * 17)));
        check("b2b_idle_after", w[327:320], 8'hFF);
        apb_rd(8'h04, d, err);
        check("b2b_status", d, 32'h06);

        // Framing error: 0x55 with a low stop bit, then a good frame to prove re-arm.
        apb_wr(8'h0C, 32'h12, err);
        rx_bits({6'd0, 1'b0, 8'h55, 1'b0}, 10);
        repeat (8) @(negedge PCLK);
        rx_drv = 1'b1;
        repeat (8) @(negedge PCLK);
        apb_rd(8'h04, d, err);
        check("ferr_set", d[5], 1'b1);
        check("ferr_rx_empty", d[2], 1'b1);
        check("irq_err", irq, 1'b1);
        apb_wr(8'h04, 32'h20, err);
        apb_rd(8'h04, d, err);
        check("ferr_clear", d, 32'h06);
        check("irq_err_clear", irq, 1'b0);
        rx_bits({6'd0, 1'b1, 8'hA3, 1'b0}, 10);
        repeat (8) @(negedge PCLK);
        apb_rd(8'h00, d, err);
        check("rearm_rd", d, 32'hA3);
        check("rearm_rd_err", err, 1'b0);

`ifdef UART_PARITY_EN
        apb_wr(8'h0C, 32'h32, err);
        apb_rd(8'h0C, d, err);
        check("ctrl_par_rw", d, 32'h32);
        // 0x07 has three ones: even parity bit would be 1, send 0.
        rx_bits({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge PCLK);
        apb_rd(8'h04, d, err);
        check("perr_set", d[6], 1'b1);
        check("perr_rx_empty", d[2], 1'b1);
        check("irq_perr", irq, 1'b1);
        apb_wr(8'h04, 32'h40, err);
`else
        apb_wr(8'h0C, 32'h20, err);
        apb_rd(8'h0C, d, err);
        check("ctrl_par_ro", d, 32'h0);
`endif

        // Reset in the middle of a character.
        apb_wr(8'h0C, 32'h01, err);
        apb_wr(8'h00, 32'h00, err);
        wait_start("rst_char_start");
        repeat (6) @(negedge PCLK);
        check("rst_char_low", tx, 1'b0);
        #2 PRESETn = 1'b0;
        #1 check("async_rst_tx", tx, 1'b1);
        check("async_rst_irq", irq, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        apb_rd(8'h04, d, err);
        check("post_rst_status", d, 32'h06);
        apb_rd(8'h0C, d, err);
        check("post_rst_ctrl", d, 32'h0);
        apb_rd(8'h08, d, err);
        check("post_rst_div", d, 32'd433);
        repeat (50) @(negedge PCLK);
        check("post_rst_tx_idle", tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
